// File: rtl/timebase_pkg.sv
// Shared defaults, channel operation encoding and the half-period helper
// for the timebase generator.
package timebase_pkg;

  localparam int unsigned SEL_W_DEF = 2;
  localparam int unsigned CNT_W_DEF = 20;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_RUN,
    OP_SYNC
  } ch_op_t;

  function automatic longint unsigned half_period(longint unsigned base, int unsigned sel);
    return base << sel;
  endfunction

endpackage

// File: rtl/timebase_channel.sv
// One divided-clock channel: counter, select latch, square-wave toggle and
// toggle tick. All outputs are registered.
module timebase_channel
  import timebase_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned BASE  = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic [SEL_W-1:0] sel,
  output logic             clk_out,
  output logic             tick,
  output logic [SEL_W-1:0] active_sel
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;
  logic             wrap;
  ch_op_t           op;

  always_comb begin
    // Modulo-2^CNT_W arithmetic keeps a half-period of exactly 2^CNT_W
    // correct: the shifted value wraps to 0 and minus one gives all ones.
    term = (CNT_W'(BASE) << active_sel) - CNT_W'(1);
    wrap = (cnt == term);
    op   = OP_HOLD;
    if (sync) begin
      op = OP_SYNC;
    end else if (en) begin
      op = OP_RUN;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      clk_out    <= 1'b1;
      tick       <= 1'b0;
      active_sel <= '0;
    end else begin
      case (op)
        OP_SYNC: begin
          cnt        <= '0;
          clk_out    <= 1'b1;
          tick       <= 1'b0;
          active_sel <= sel;
        end
        OP_RUN: begin
          tick <= wrap;
          if (wrap) begin
            cnt        <= '0;
            clk_out    <= ~clk_out;
            active_sel <= sel;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/timebase_generator.sv
// Multi-channel timebase: N_CH independent divided clocks sharing one
// enable and one synchronous realign.
module timebase_generator
  import timebase_pkg::*;
#(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned SEL_W = SEL_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned BASE  = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sync,
  input  logic [N_CH*SEL_W-1:0] sel,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH*SEL_W-1:0] active_sel
);

  localparam longint unsigned MAX_HALF =
    half_period(longint'(BASE), (32'd1 << SEL_W) - 32'd1);
  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

  generate
    if (BASE == 0 || MAX_HALF > CNT_SPAN) begin : g_bad_cfg
      $fatal(1, "timebase_generator: BASE=%0d SEL_W=%0d does not fit CNT_W=%0d",
             BASE, SEL_W, CNT_W);
    end
  endgenerate

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    timebase_channel #(
      .SEL_W (SEL_W),
      .CNT_W (CNT_W),
      .BASE  (BASE)
    ) u_channel (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .en         (en),
      .sync       (sync),
      .sel        (sel[k*SEL_W +: SEL_W]),
      .clk_out    (clk_out[k]),
      .tick       (tick[k]),
      .active_sel (active_sel[k*SEL_W +: SEL_W])
    );
  end

endmodule

// File: tb/tb_timebase_generator.sv
// Self-checking bench for timebase_generator: table-driven ratio vectors,
// hand sequences for select change, hold, sync, reset and a large BASE.
module tb_timebase_generator;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       sync;
  logic [3:0] sel;
  logic [1:0] clk_out;
  logic [1:0] tick;
  logic [3:0] active_sel;

  logic       en2;
  logic       sync2;
  logic [1:0] sel2;
  logic       clk_out2;
  logic       tick2;
  logic [1:0] active_sel2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] clk;
    logic [1:0] tick;
    logic [3:0] asel;
    string      name;
  } exp_t;

  typedef struct {
    logic       en;
    logic       sync;
    logic [3:0] sel;
    logic [1:0] clk;
    logic [1:0] tick;
    logic [3:0] asel;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[17];

  timebase_generator #(
    .N_CH  (2),
    .SEL_W (2),
    .CNT_W (20),
    .BASE  (1)
  ) dut (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sync       (sync),
    .sel        (sel),
    .clk_out    (clk_out),
    .tick       (tick),
    .active_sel (active_sel)
  );

  timebase_generator #(
    .N_CH  (1),
    .SEL_W (2),
    .CNT_W (20),
    .BASE  (25000)
  ) dut_big (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .en         (en2),
    .sync       (sync2),
    .sel        (sel2),
    .clk_out    (clk_out2),
    .tick       (tick2),
    .active_sel (active_sel2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out();
    exp_t x;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got no expectation, want one queued");
      return;
    end
    x = sbq.pop_front();
    total++;
    if ({clk_out, tick, active_sel} !== {x.clk, x.tick, x.asel}) begin
      bad++;
      $display("FAIL %s: got clk_out=%b tick=%b active_sel=%b, want clk_out=%b tick=%b active_sel=%b",
               x.name, clk_out, tick, active_sel, x.clk, x.tick, x.asel);
    end
  endtask

  task automatic step(input logic e, input logic s, input logic [3:0] sl,
                      input logic [1:0] xc, input logic [1:0] xt,
                      input logic [3:0] xa, input string nm);
    en   = e;
    sync = s;
    sel  = sl;
    sbq.push_back('{xc, xt, xa, nm});
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    sync  = 1'b0;
    sel   = 4'b0000;
    en2   = 1'b0;
    sync2 = 1'b0;
    sel2  = 2'b10;

    // Basic ratios: sync to load sel={3,0}, then 16 enabled cycles.
    vecs[0] = '{1'b1, 1'b1, 4'b1100, 2'b11, 2'b00, 4'b1100};
    for (int k = 1; k <= 16; k++) begin
      vecs[k] = '{1'b1, 1'b0, 4'b1100,
                  {1'(k < 8 || k == 16), 1'(k % 2 == 0)},
                  {1'(k % 8 == 0), 1'b1},
                  4'b1100};
    end

    #12;
    sbq.push_back('{2'b11, 2'b00, 4'b0000, "reset_state"});
    check_out();
    chk("reset_state_big", {clk_out2, tick2, active_sel2}, 4'b1000);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].en, vecs[i].sync, vecs[i].sel, vecs[i].clk, vecs[i].tick,
           vecs[i].asel, $sformatf("ratio[%0d]", i));
    end

    // ch1 select drops to 0 at count 3; current 8-cycle half-period finishes.
    for (int k = 17; k <= 26; k++) begin
      step(1'b1, 1'b0, (k <= 19) ? 4'b1100 : 4'b0000,
           {(k < 24) ? 1'b1 : 1'(k % 2), 1'(k % 2 == 0)},
           {1'(k >= 24), 1'b1},
           (k >= 24) ? 4'b0000 : 4'b1100,
           $sformatf("sel_change[%0d]", k));
    end

    // Hold for 5 cycles at ch1 count 4, then the toggle lands 4 cycles later.
    step(1'b1, 1'b1, 4'b1100, 2'b11, 2'b00, 4'b1100, "hold_sync");
    for (int j = 1; j <= 4; j++) begin
      step(1'b1, 1'b0, 4'b1100, {1'b1, 1'(j % 2 == 0)}, 2'b01, 4'b1100,
           $sformatf("hold_pre[%0d]", j));
    end
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 1'b0, 4'b1100, 2'b11, 2'b00, 4'b1100, $sformatf("hold_frozen[%0d]", j));
    end
    for (int j = 5; j <= 11; j++) begin
      step(1'b1, 1'b0, 4'b1100,
           {1'(j < 8), 1'(j % 2 == 0)},
           {1'(j == 8), 1'b1},
           4'b1100, $sformatf("hold_resume[%0d]", j));
    end

    // Sync at arbitrary counts with sel={3,3}: both channels realign.
    step(1'b1, 1'b1, 4'b1111, 2'b11, 2'b00, 4'b1111, "sync_load");
    for (int m = 1; m <= 16; m++) begin
      step(1'b1, 1'b0, 4'b1111,
           (m < 8 || m == 16) ? 2'b11 : 2'b00,
           (m % 8 == 0) ? 2'b11 : 2'b00,
           4'b1111, $sformatf("sync_run[%0d]", m));
    end

    // Asynchronous reset between clock edges, checked before any edge.
    #3;
    rst_n = 1'b0;
    sbq.push_back('{2'b11, 2'b00, 4'b0000, "async_reset"});
    #1;
    check_out();
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'b0000, 2'b00, 2'b11, 4'b0000, "post_reset[0]");
    step(1'b1, 1'b0, 4'b0000, 2'b11, 2'b11, 4'b0000, "post_reset[1]");

    // BASE=25000: first half-period after reset is 25000 cycles, then sel=2 latches.
    en  = 1'b0;
    en2 = 1'b1;
    repeat (24999) @(posedge clk);
    #1;
    chk("big_before_toggle", {clk_out2, tick2, active_sel2}, 4'b1000);
    @(posedge clk);
    #1;
    chk("big_toggle", {clk_out2, tick2, active_sel2}, 4'b0110);
    @(posedge clk);
    #1;
    chk("big_after_toggle", {clk_out2, tick2, active_sel2}, 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timebase_generator.md
TIMEBASE_GENERATOR -- requirements
Module: timebase_generator

Interface
REQ-001 SHALL take parameter N_CH, default 2, the number of independent divided-clock channels.
REQ-002 SHALL take parameter SEL_W, default 2, the width of each channel's ratio select.
REQ-003 SHALL take parameter CNT_W, default 20, the width of each channel's counter.
REQ-004 SHALL take parameter BASE, default 1, the half-period in clk_in cycles at select 0.
REQ-005 SHALL have port clk_in  input  1  the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port en  input  1  run enable, common to all channels.
REQ-008 SHALL have port sync  input  1  synchronous realign of all channels.
REQ-009 SHALL have port sel  input  N_CH*SEL_W  requested ratio select per channel; channel k uses bits [k*SEL_W +: SEL_W].
REQ-010 SHALL have port clk_out  output  N_CH  divided square wave per channel.
REQ-011 SHALL have port tick  output  N_CH  one-cycle pulse per channel, coincident with each clk_out toggle.
REQ-012 SHALL have port active_sel  output  N_CH*SEL_W  select currently in force per channel.

Function
REQ-013 SHALL compute the half-period of channel k as H_k = BASE << active_sel_k clk_in cycles.
REQ-014 SHALL, with en=1 and sync=0, increment cnt_k each cycle; when cnt_k == H_k-1 the channel SHALL clear cnt_k, invert clk_out[k], and assert tick[k] in that same cycle.
REQ-015 SHALL sample the requested sel_k into active_sel_k only at a toggle cycle, so no half-period is ever shortened or truncated by a mid-period select change.
REQ-016 SHALL, with en=0 and sync=0, hold cnt, clk_out and active_sel, and drive tick to 0.
REQ-017 SHALL, when sync=1 and regardless of en, clear every cnt_k, drive clk_out to all ones, load active_sel from sel, and drive tick to 0.
REQ-018 SHALL produce outputs registered only; each clk_out[k] edge SHALL be one cycle after the counter reaches the terminal value, with no combinational path from inputs to outputs.
REQ-019 SHALL, with BASE=1 and active_sel=0, toggle clk_out[k] on every cycle, with tick[k] held at 1 while en=1.
REQ-020 SHALL run each channel independently; a select change or terminal count on one channel SHALL NOT affect any other channel.
REQ-021 SHALL reject at elaboration any configuration where BASE << (2^SEL_W - 1) exceeds 2^CNT_W, or where BASE = 0.

Reset
REQ-022 SHALL, when rst_n=0, immediately and asynchronously set cnt to 0, clk_out to all ones, tick to all zeros, and active_sel to all zeros.
REQ-023 SHALL, on a reset asserted mid-period, discard the partial period; the first toggle after release SHALL occur H_k cycles after the first enabled edge.

Structure
REQ-024 SHALL place the default values of SEL_W and CNT_W, plus a half_period(base, sel) function, in shared package timebase_pkg.
REQ-025 SHALL implement one channel (counter, select latch, toggle and tick) as sub-module timebase_channel, instantiated N_CH times in a generate loop.

Verification
REQ-026 SHALL cover basic ratios: N_CH=2, BASE=1, sel={3,0}, en=1 -> ch0 toggles every cycle; ch1 toggles every 8 cycles with tick[1] pulsing once per 8 cycles.
REQ-027 SHALL cover a mid-period select change: ch1 sel changes 3->0 at count 3 -> the current 8-cycle half-period completes, then ch1 toggles every cycle and active_sel reads 0.
REQ-028 SHALL cover hold: en=0 for 5 cycles at ch1 count 4 -> outputs frozen and tick=0; after en returns to 1, the toggle occurs 4 cycles later.
REQ-029 SHALL cover sync: sync pulsed with en=1 at arbitrary counts -> next cycle clk_out=11 and all counts are 0; both channels then toggle together every 8 cycles with sel={3,3}.
REQ-030 SHALL cover reset mid-operation: rst_n low between clock edges -> clk_out=11, tick=00 and active_sel=0 without any clock edge.
REQ-031 SHALL cover BASE=25000, sel=2, CNT_W=20 -> half-period of 100000 cycles, with the elaboration check passing.
